// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for the multi-cycle MIPS datapath. One instruction takes
// 3 to 5 cycles: FETCH, DECODE, then a class-specific execute/memory/
// writeback tail. Decodes op/funct from the externally held instruction
// register and drives datapath selects, enables and ALU control.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_ni        asynchronous active-low reset (0 = in reset)
//   op_i          instr[31:26] from the instruction register
//   funct_i       instr[5:0]
//   zero_i        ALU zero flag
//   memtoreg_o    0 = aluout, 1 = data register to regfile
//   regdst_o      0 = rt, 1 = rd as write address
//   iord_o        0 = pc, 1 = aluout as memory address
//   pcsrc_o       00 aluresult, 01 aluout, 10 jump target
//   alusrcb_o     00 b, 01 4, 10 imm, 11 imm<<2
//   alusrca_o     0 = pc, 1 = a
//   irwrite_o     instruction register load
//   pcen_o        PC register enable
//   regwrite_o    register file write
//   memwrite_o    memory write
//   alucontrol_o  010 add, 110 sub, 000 and, 001 or, 111 slt
//   immext_o      0 = sign-extend, 1 = zero-extend immediate
//   state_o       current state (debug)
//   illegal_o     pulse for unsupported opcode / funct
module multicycle_controller #(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       memtoreg_o,
  output logic       regdst_o,
  output logic       iord_o,
  output logic [1:0] pcsrc_o,
  output logic [1:0] alusrcb_o,
  output logic       alusrca_o,
  output logic       irwrite_o,
  output logic       pcen_o,
  output logic       regwrite_o,
  output logic       memwrite_o,
  output logic [2:0] alucontrol_o,
  output logic       immext_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    IEX     = 4'd9,
    IWB     = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  // Ungated write enables; the final outputs are masked by reset below.
  logic pcenRaw, irwriteRaw, regwriteRaw, memwriteRaw;

  // State register: reset lands in FETCH immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Next state and Moore outputs (op/funct/zero only where decoded).
  always_comb begin
    state_d      = FETCH;
    memtoreg_o   = 1'b0;
    regdst_o     = 1'b0;
    iord_o       = 1'b0;
    pcsrc_o      = 2'b00;
    alusrcb_o    = 2'b00;
    alusrca_o    = 1'b0;
    irwriteRaw   = 1'b0;
    pcenRaw      = 1'b0;
    regwriteRaw  = 1'b0;
    memwriteRaw  = 1'b0;
    alucontrol_o = ALU_ADD;
    immext_o     = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb_o  = 2'b01;
        irwriteRaw = 1'b1;
        pcenRaw    = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into aluout.
        alusrcb_o = 2'b11;
        case (op_i)
          OP_LW, OP_SW:                     state_d = MEMADR;
          OP_RTYP:                          state_d = RTYPEEX;
          OP_BEQ:                           state_d = BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEX;
          OP_J:                             state_d = JEX;
          OP_BNE: begin
            if (ENABLE_BNE) state_d = BNEEX;
            else            illegal_o = 1'b1;
          end
          default:                          illegal_o = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = (op_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord_o  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg_o  = 1'b1;
        regwriteRaw = 1'b1;
      end
      MEMWR: begin
        iord_o      = 1'b1;
        memwriteRaw = 1'b1;
      end
      RTYPEEX: begin
        alusrca_o = 1'b1;
        state_d   = RTYPEWB;
        case (funct_i)
          6'b100000: alucontrol_o = ALU_ADD;
          6'b100010: alucontrol_o = ALU_SUB;
          6'b100100: alucontrol_o = ALU_AND;
          6'b100101: alucontrol_o = ALU_OR;
          6'b101010: alucontrol_o = ALU_SLT;
          default:   illegal_o    = 1'b1;
        endcase
      end
      RTYPEWB: begin
        regdst_o    = 1'b1;
        regwriteRaw = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca_o    = 1'b1;
        alucontrol_o = ALU_SUB;
        pcsrc_o      = 2'b01;
        pcenRaw      = (state_q == BEQEX) ? zero_i : ~zero_i;
      end
      IEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = IWB;
        case (op_i)
          OP_ANDI: begin alucontrol_o = ALU_AND; immext_o = 1'b1; end
          OP_ORI:  begin alucontrol_o = ALU_OR;  immext_o = 1'b1; end
          OP_SLTI: alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      IWB: regwriteRaw = 1'b1;
      JEX: begin
        pcsrc_o = 2'b10;
        pcenRaw = 1'b1;
      end
      default: begin
        // Unused codes: everything zero, recover to FETCH.
        alucontrol_o = 3'b000;
      end
    endcase
  end

  // Write enables are held low while reset is asserted, even though the
  // state register already shows FETCH.
  assign pcen_o     = pcenRaw     & rst_ni;
  assign irwrite_o  = irwriteRaw  & rst_ni;
  assign regwrite_o = regwriteRaw & rst_ni;
  assign memwrite_o = memwriteRaw & rst_ni;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Scoreboard bench: the driver issues one instruction at a time and
// pushes the expected per-cycle control word for every cycle of that
// instruction; a negedge monitor pops and compares. The expected words
// come from an instruction-level cycle table, not from the FSM code.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic       alusrca;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       memwrite;
    logic [2:0] aluctl;
    logic       immext;
    logic       illegal;
  } cyc_t;

  logic       clk;
  logic       rstN;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memtoreg, regdst, iord, alusrca, irwrite, pcen;
  logic       regwrite, memwrite, immext, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state;

  cyc_t  dutCyc;
  cyc_t  sbQ[$];
  string tagQ[$];
  int    total = 0;
  int    bad   = 0;

  multicycle_controller #(.ENABLE_BNE(1'b1)) dut (
    .clk_i(clk), .rst_ni(rstN), .op_i(op), .funct_i(funct), .zero_i(zero),
    .memtoreg_o(memtoreg), .regdst_o(regdst), .iord_o(iord),
    .pcsrc_o(pcsrc), .alusrcb_o(alusrcb), .alusrca_o(alusrca),
    .irwrite_o(irwrite), .pcen_o(pcen), .regwrite_o(regwrite),
    .memwrite_o(memwrite), .alucontrol_o(alucontrol), .immext_o(immext),
    .state_o(state), .illegal_o(illegal)
  );

  assign dutCyc = {state, memtoreg, regdst, iord, pcsrc, alusrcb, alusrca,
                   irwrite, pcen, regwrite, memwrite, alucontrol, immext,
                   illegal};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected word per cycle while an instruction is queued.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      cyc_t  exp;
      string tag;
      exp = sbQ.pop_front();
      tag = tagQ.pop_front();
      total++;
      if (dutCyc !== exp) begin
        bad++;
        $display("[TB] FAIL %s: got %h expected %h", tag, dutCyc, exp);
      end
    end
  end

  // Idle word for a state: add on the ALU, everything else quiet.
  function automatic cyc_t idle(input logic [3:0] st);
    cyc_t c;
    c = '0;
    c.st = st;
    c.aluctl = 3'b010;
    return c;
  endfunction

  // Instruction-level cycle table: FETCH, DECODE, then the tail for the
  // instruction class. Returns the number of cycles pushed.
  task automatic pushInstr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input string name, output int n);
    cyc_t  seq[$];
    cyc_t  c;
    bit    legal;
    legal = (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                       6'b000101, 6'b001000, 6'b001100, 6'b001101,
                       6'b001010, 6'b000010});
    c = idle(4'd0); c.alusrcb = 2'b01; c.irwrite = 1; c.pcen = 1;
    seq.push_back(c);
    c = idle(4'd1); c.alusrcb = 2'b11; c.illegal = !legal;
    seq.push_back(c);
    case (o)
      6'b100011, 6'b101011: begin
        c = idle(4'd2); c.alusrca = 1; c.alusrcb = 2'b10; seq.push_back(c);
        if (o == 6'b100011) begin
          c = idle(4'd3); c.iord = 1; seq.push_back(c);
          c = idle(4'd4); c.memtoreg = 1; c.regwrite = 1; seq.push_back(c);
        end else begin
          c = idle(4'd5); c.iord = 1; c.memwrite = 1; seq.push_back(c);
        end
      end
      6'b000000: begin
        c = idle(4'd6); c.alusrca = 1;
        case (f)
          6'b100000: c.aluctl = 3'b010;
          6'b100010: c.aluctl = 3'b110;
          6'b100100: c.aluctl = 3'b000;
          6'b100101: c.aluctl = 3'b001;
          6'b101010: c.aluctl = 3'b111;
          default:   c.illegal = 1;
        endcase
        seq.push_back(c);
        c = idle(4'd7); c.regdst = 1; c.regwrite = 1; seq.push_back(c);
      end
      6'b000100, 6'b000101: begin
        c = idle((o == 6'b000100) ? 4'd8 : 4'd12);
        c.alusrca = 1; c.aluctl = 3'b110; c.pcsrc = 2'b01;
        c.pcen = (o == 6'b000100) ? z : !z;
        seq.push_back(c);
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        c = idle(4'd9); c.alusrca = 1; c.alusrcb = 2'b10;
        if (o == 6'b001100) begin c.aluctl = 3'b000; c.immext = 1; end
        if (o == 6'b001101) begin c.aluctl = 3'b001; c.immext = 1; end
        if (o == 6'b001010) c.aluctl = 3'b111;
        seq.push_back(c);
        c = idle(4'd10); c.regwrite = 1; seq.push_back(c);
      end
      6'b000010: begin
        c = idle(4'd11); c.pcsrc = 2'b10; c.pcen = 1; seq.push_back(c);
      end
      default: ;
    endcase
    n = seq.size();
    foreach (seq[i]) begin
      sbQ.push_back(seq[i]);
      tagQ.push_back($sformatf("%s op=%b cyc%0d", name, o, i));
    end
  endtask

  // Called 1 time unit after a rising edge with the DUT in FETCH; holds
  // op/funct/zero stable for the whole instruction.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input string name);
    int n;
    op = o; funct = f; zero = z;
    pushInstr(o, f, z, name, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [5:0] opTab[12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000101, 6'b001000, 6'b001100, 6'b001101,
                            6'b001010, 6'b000010, 6'b111111, 6'b010001};
  logic [5:0] fnTab[6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010, 6'b000111};

  initial begin
    int n;
    rstN = 1'b0; op = '0; funct = '0; zero = 1'b0;
    $display("[TB] reset held for 3 cycles");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset enables", 32'({pcen, irwrite, regwrite, memwrite}), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;

    applyStimulus(6'b100011, 6'b000000, 1'b0, "lw");
    applyStimulus(6'b000000, 6'b101010, 1'b0, "slt");
    applyStimulus(6'b000100, 6'b000000, 1'b1, "beq taken");
    applyStimulus(6'b000100, 6'b000000, 1'b0, "beq not taken");
    applyStimulus(6'b000101, 6'b000000, 1'b0, "bne taken");
    applyStimulus(6'b001101, 6'b000000, 1'b0, "ori");
    applyStimulus(6'b111111, 6'b000000, 1'b0, "illegal op");
    applyStimulus(6'b000000, 6'b111111, 1'b0, "illegal funct");
    applyStimulus(6'b000010, 6'b000000, 1'b0, "j");

    // sw interrupted by reset while in MEMWR.
    $display("[TB] reset during sw write cycle");
    op = 6'b101011; funct = '0; zero = 1'b0;
    pushInstr(op, funct, zero, "sw pre-reset", n);
    void'(sbQ.pop_back());
    void'(tagQ.pop_back());
    repeat (3) @(posedge clk);
    #1;
    checkOutput("memwr state", 32'(state), 32'd5);
    checkOutput("memwr memwrite", 32'(memwrite), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midreset memwrite", 32'(memwrite), 32'd0);
    checkOutput("midreset state", 32'(state), 32'd0);
    checkOutput("midreset enables", 32'({pcen, irwrite, regwrite}), 32'd0);
    @(posedge clk); #1;
    checkOutput("held reset state", 32'(state), 32'd0);
    rstN = 1'b1;
    applyStimulus(6'b101011, 6'b000000, 1'b0, "sw after reset");

    $display("[TB] random instruction stream");
    for (int i = 0; i < 200; i++) begin
      logic [5:0] o, f;
      logic       z;
      o = opTab[$urandom_range(0, 11)];
      f = fnTab[$urandom_range(0, 5)];
      z = 1'($urandom_range(0, 1));
      applyStimulus(o, f, z, "rand");
    end

    @(posedge clk); #1;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
